// File: rtl/elevator_pkg.sv
// Shared elevator definitions: controller state encoding and timer sizing helper.
// Imported by every elevator block so state values stay consistent across the family.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } elev_state_t;

  localparam int DEF_N_FLOORS    = 8;
  localparam int DEF_FLOOR_W     = 3;
  localparam int DEF_STEP_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 6;

  // Counter width able to hold the value "cycles" itself (the timer is loaded with it).
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: load has priority, enable decrements, expire flags the
// final enabled cycle so the owner can act on the same edge the count reaches zero.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = enable && (count == W'(1));

endmodule

// File: rtl/elevator_floor_fsm.sv
// Single-car floor controller: accepts a go-to request or a one-floor jog while idle,
// steps one floor per STEP_CYCLES, holds the door for DOOR_CYCLES, and freezes on P.
module elevator_floor_fsm
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic               up,
  input  logic               down,
  input  logic               P,
  output logic               req_ready,
  output logic               req_err,
  output logic [FLOOR_W-1:0] floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               alarm,
  output logic               at_bottom
);

  localparam int STEP_W = timer_width(STEP_CYCLES);
  localparam int DOOR_W = timer_width(DOOR_CYCLES);

  // One extra bit so N_FLOORS itself is representable when it equals 2**FLOOR_W.
  localparam logic [FLOOR_W:0]   N_FLOORS_EXT = (FLOOR_W + 1)'(N_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(N_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] ONE_FLOOR    = FLOOR_W'(1);
  localparam logic [STEP_W-1:0]  STEP_LOAD    = STEP_W'(STEP_CYCLES);
  localparam logic [DOOR_W-1:0]  DOOR_LOAD    = DOOR_W'(DOOR_CYCLES);

  elev_state_t        state;
  logic [FLOOR_W-1:0] target;

  logic               in_range;
  logic               at_top;
  logic               at_floor0;
  logic               accept;
  logic               go_req;
  logic               bad_req;
  logic               jog_up;
  logic               jog_down;
  logic               start_up;
  logic               start_down;
  logic               start_door;
  logic [FLOOR_W-1:0] floor_up;
  logic [FLOOR_W-1:0] floor_dn;
  logic [FLOOR_W-1:0] start_target;
  logic [FLOOR_W-1:0] next_floor;
  logic               step_run;
  logic               door_run;
  logic               step_expire;
  logic               door_expire;
  logic               arrive;
  logic               step_load;
  logic               door_load;

  assign in_range  = {1'b0, req_floor} < N_FLOORS_EXT;
  assign at_top    = (floor == TOP_FLOOR);
  assign at_floor0 = (floor == '0);
  assign floor_up  = floor + ONE_FLOOR;
  assign floor_dn  = floor - ONE_FLOOR;

  // Request handling: explicit request beats up-jog, up-jog beats down-jog.
  assign req_ready = (state == ST_IDLE) && !P;
  assign accept    = req_ready && req_valid;
  assign go_req    = accept && in_range;
  assign bad_req   = accept && !in_range;
  assign jog_up    = req_ready && !req_valid && !up && !at_top;
  assign jog_down  = req_ready && !req_valid && !jog_up && !down && !at_floor0;

  assign start_up     = (go_req && (req_floor > floor)) || jog_up;
  assign start_down   = (go_req && (req_floor < floor)) || jog_down;
  assign start_door   = go_req && (req_floor == floor);
  assign start_target = go_req ? req_floor : (jog_up ? floor_up : floor_dn);

  assign step_run   = ((state == ST_MOVE_UP) || (state == ST_MOVE_DOWN)) && !P;
  assign door_run   = (state == ST_DOOR_OPEN) && !P;
  assign next_floor = (state == ST_MOVE_UP) ? floor_up : floor_dn;

  // Reaching an end floor also stops the car, so the floor can never wrap.
  assign arrive = step_expire &&
                  ((next_floor == target) ||
                   ((state == ST_MOVE_UP)   && (next_floor == TOP_FLOOR)) ||
                   ((state == ST_MOVE_DOWN) && (next_floor == '0)));

  assign step_load = start_up || start_down || (step_expire && !arrive);
  assign door_load = start_door || arrive;

  cycle_timer #(
    .W (STEP_W)
  ) u_step_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (step_load),
    .load_value (STEP_LOAD),
    .enable     (step_run),
    .expire     (step_expire)
  );

  cycle_timer #(
    .W (DOOR_W)
  ) u_door_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (door_load),
    .load_value (DOOR_LOAD),
    .enable     (door_run),
    .expire     (door_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      floor       <= '0;
      target      <= '0;
      req_err     <= 1'b0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      req_err <= bad_req;
      case (state)
        ST_IDLE: begin
          if (start_up) begin
            state       <= ST_MOVE_UP;
            target      <= start_target;
            moving_up   <= 1'b1;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
          end else if (start_down) begin
            state       <= ST_MOVE_DOWN;
            target      <= start_target;
            moving_up   <= 1'b0;
            moving_down <= 1'b1;
            door_open   <= 1'b0;
          end else if (start_door) begin
            state       <= ST_DOOR_OPEN;
            target      <= req_floor;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (step_expire) begin
            floor <= next_floor;
            if (arrive) begin
              state       <= ST_DOOR_OPEN;
              moving_up   <= 1'b0;
              moving_down <= 1'b0;
              door_open   <= 1'b1;
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (door_expire) begin
            state       <= ST_IDLE;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          moving_up   <= 1'b0;
          moving_down <= 1'b0;
          door_open   <= 1'b0;
        end
      endcase
    end
  end

  assign alarm     = at_top;
  assign at_bottom = at_floor0;

endmodule

// File: tb/tb_elevator_floor_fsm.sv
// Scoreboard bench for elevator_floor_fsm: each driven cycle pushes the expected
// outputs derived from travel progress; each clock edge pops and compares them.
module tb_elevator_floor_fsm;

  localparam int N_FLOORS    = 8;
  localparam int FLOOR_W     = 4;
  localparam int STEP_CYCLES = 4;
  localparam int DOOR_CYCLES = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               up;
  logic               down;
  logic               P;
  logic               req_ready;
  logic               req_err;
  logic [FLOOR_W-1:0] floor;
  logic               moving_up;
  logic               moving_down;
  logic               door_open;
  logic               alarm;
  logic               at_bottom;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int fl;
    int mu;
    int md;
    int dr;
    int rdy;
    int err;
  } exp_t;

  exp_t sb_q[$];

  elevator_floor_fsm #(
    .N_FLOORS    (N_FLOORS),
    .FLOOR_W     (FLOOR_W),
    .STEP_CYCLES (STEP_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .up          (up),
    .down        (down),
    .P           (P),
    .req_ready   (req_ready),
    .req_err     (req_err),
    .floor       (floor),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .alarm       (alarm),
    .at_bottom   (at_bottom)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_floor = '0;
    up        = 1'b1;
    down      = 1'b1;
    P         = 1'b0;
  endtask

  // Expected outputs after "eff" un-paused edges since the accepting edge.
  function automatic exp_t trip_model(input int src, input int dst, input int eff, input bit p);
    exp_t e;
    int   d;
    int   tm;
    d     = (dst > src) ? dst - src : src - dst;
    tm    = STEP_CYCLES * d;
    e.fl  = dst;
    e.mu  = 0;
    e.md  = 0;
    e.dr  = 0;
    e.rdy = 0;
    e.err = 0;
    if (eff < tm) begin
      e.fl = (dst > src) ? src + eff / STEP_CYCLES : src - eff / STEP_CYCLES;
      e.mu = (dst > src) ? 1 : 0;
      e.md = (dst < src) ? 1 : 0;
    end else if (eff < tm + DOOR_CYCLES) begin
      e.dr = 1;
    end else begin
      e.rdy = p ? 0 : 1;
    end
    return e;
  endfunction

  task automatic tick_and_compare(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_value({tag, "_floor"},  int'(floor),       e.fl);
      check_value({tag, "_mu"},     int'(moving_up),   e.mu);
      check_value({tag, "_md"},     int'(moving_down), e.md);
      check_value({tag, "_door"},   int'(door_open),   e.dr);
      check_value({tag, "_ready"},  int'(req_ready),   e.rdy);
      check_value({tag, "_err"},    int'(req_err),     e.err);
      check_value({tag, "_alarm"},  int'(alarm),       (e.fl == N_FLOORS - 1) ? 1 : 0);
      check_value({tag, "_bottom"}, int'(at_bottom),   (e.fl == 0) ? 1 : 0);
    end
  endtask

  // One idle cycle with the given inputs; the car must stay put at floor fl.
  task automatic idle_cycle(input string tag, input int fl, input bit v, input int rf,
                            input bit u, input bit dn, input bit p, input int exp_err);
    exp_t e;
    req_valid = v;
    req_floor = FLOOR_W'(rf);
    up        = u;
    down      = dn;
    P         = p;
    e.fl  = fl;
    e.mu  = 0;
    e.md  = 0;
    e.dr  = 0;
    e.rdy = p ? 0 : 1;
    e.err = exp_err;
    sb_q.push_back(e);
    tick_and_compare(tag);
    idle_inputs();
    $display("IDLE %s floor=%0d req=%0b/%0d up=%0b down=%0b P=%0b err=%0b",
             tag, floor, v, rf, u, dn, p, req_err);
  endtask

  // mode: 0 request, 1 jog up, 2 jog down, 3 both jogs low.
  task automatic trip(input string tag, input int src, input int dst, input int mode,
                      input int pause_at, input int pause_len, input bit noise,
                      input int stop_after);
    int d;
    int tm;
    int eff;
    int k;
    int arrive_k;
    d        = (dst > src) ? dst - src : src - dst;
    tm       = STEP_CYCLES * d;
    eff      = 0;
    k        = 0;
    arrive_k = -1;
    idle_inputs();
    case (mode)
      0:       begin req_valid = 1'b1; req_floor = FLOOR_W'(dst); end
      1:       up = 1'b0;
      2:       down = 1'b0;
      default: begin up = 1'b0; down = 1'b0; end
    endcase
    sb_q.push_back(trip_model(src, dst, eff, 1'b0));
    tick_and_compare(tag);
    if (door_open && arrive_k < 0) arrive_k = k;
    idle_inputs();
    while (eff < tm + DOOR_CYCLES && (stop_after < 0 || k < stop_after)) begin
      k++;
      P = (pause_at > 0 && k >= pause_at && k < pause_at + pause_len);
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_floor = FLOOR_W'($urandom_range(0, 15));
        up        = 1'($urandom_range(0, 1));
        down      = 1'($urandom_range(0, 1));
      end
      if (!P) eff++;
      sb_q.push_back(trip_model(src, dst, eff, P));
      tick_and_compare(tag);
      if (door_open && arrive_k < 0) arrive_k = k;
    end
    idle_inputs();
    if (stop_after < 0) check_value({tag, "_arrival_cycles"}, arrive_k, tm + pause_len);
    $display("TRIP %s %0d->%0d mode=%0d edges=%0d arrive=%0d floor=%0d",
             tag, src, dst, mode, k, arrive_k, floor);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    check_value("rst_floor",  int'(floor),       0);
    check_value("rst_ready",  int'(req_ready),   1);
    check_value("rst_flags",  int'({moving_up, moving_down, door_open}), 0);
    check_value("rst_err",    int'(req_err),     0);
    check_value("rst_alarm",  int'(alarm),       0);
    check_value("rst_bottom", int'(at_bottom),   1);
    P = 1'b1;
    #1;
    check_value("rst_ready_paused", int'(req_ready), 0);
    P = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    idle_cycle("post_reset", 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    trip("req0to5", 0, 5, 0, 0, 0, 1'b1, -1);
    trip("same5", 5, 5, 0, 0, 0, 1'b0, -1);
    idle_cycle("rej9", 5, 1'b1, 9, 1'b1, 1'b1, 1'b0, 1);
    idle_cycle("err_clear", 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    idle_cycle("rej8", 5, 1'b1, 8, 1'b1, 1'b1, 1'b0, 1);
    idle_cycle("pause_idle", 5, 1'b1, 2, 1'b0, 1'b0, 1'b1, 0);
    trip("req5to7", 5, 7, 0, 0, 0, 1'b0, -1);
    idle_cycle("top_up", 7, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    trip("jog_both_top", 7, 6, 3, 0, 0, 1'b0, -1);
    trip("jog_up6", 6, 7, 1, 0, 0, 1'b0, -1);
    trip("rst_mid", 7, 0, 0, 0, 0, 1'b0, 12);

    check_value("mid_floor_before_rst", int'(floor), 4);
    #2;
    reset = 1'b1;
    #1;
    check_value("mid_rst_floor",  int'(floor),       0);
    check_value("mid_rst_md",     int'(moving_down), 0);
    check_value("mid_rst_ready",  int'(req_ready),   1);
    check_value("mid_rst_bottom", int'(at_bottom),   1);
    @(negedge clk);
    reset = 1'b0;
    $display("RESET mid-move floor=%0d", floor);

    idle_cycle("bot_down", 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    trip("pause0to3", 0, 3, 0, 6, 10, 1'b0, -1);
    trip("jog_up3", 3, 4, 1, 0, 0, 1'b0, -1);
    trip("req4to1", 4, 1, 0, 0, 0, 1'b1, -1);
    trip("jog_dn1", 1, 0, 2, 0, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
